// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file write port.
// The arbiter takes the slave view; the requesters/regfile side takes the master view.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic                   a_valid;
  logic                   a_ready;
  logic [ADDR_W-1:0]      a_addr;
  logic [DATA_W-1:0]      a_data;
  logic                   b_valid;
  logic                   b_ready;
  logic [ADDR_W-1:0]      b_addr;
  logic [DATA_W-1:0]      b_data;
  logic                   hold;
  logic                   we3;
  logic [ADDR_W-1:0]      wa3;
  logic [DATA_W-1:0]      wd3;
  logic [2**ADDR_W-1:0]   busy;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold,
    output a_ready, b_ready, we3, wa3, wd3, busy
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold,
    input  a_ready, b_ready, we3, wa3, wd3, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between the ALU (A) and load (B) paths,
// with one registered issue stage and a pending-write mask for hazard detection.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int NREG = 2**ADDR_W;

  logic              out_v;
  logic              last_b;   // 1: B was granted last, so A wins the next tie
  logic [ADDR_W-1:0] wa3_q;
  logic [DATA_W-1:0] wd3_q;
  logic              free, grant_a, grant_b, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_zero;

  // The stage can take a new request when empty or when it drains this cycle.
  assign free    = !(bus.hold && out_v);
  assign grant_a = free && bus.a_valid && (!bus.b_valid || last_b);
  assign grant_b = free && bus.b_valid && (!bus.a_valid || !last_b);
  assign xfer    = grant_a || grant_b;

  assign sel_addr = grant_b ? bus.b_addr : bus.a_addr;
  assign sel_data = grant_b ? bus.b_data : bus.a_data;
  assign sel_zero = (sel_addr == ADDR_W'(ZERO_REG));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_v  <= 1'b0;
      last_b <= 1'b1;
      wa3_q  <= '0;
      wd3_q  <= '0;
    end else if (xfer) begin
      last_b <= grant_b;
      // Writes to the zero register spend the grant but never reach the regfile.
      out_v  <= !sel_zero;
      if (!sel_zero) begin
        wa3_q <= sel_addr;
        wd3_q <= sel_data;
      end
    end else if (!(out_v && bus.hold)) begin
      out_v <= 1'b0;
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign bus.we3     = out_v && !bus.hold;
  assign bus.wa3     = wa3_q;
  assign bus.wd3     = wd3_q;

  for (genvar i = 0; i < NREG; i++) begin : g_busy
    if (i == ZERO_REG) begin : g_zero
      assign bus.busy[i] = 1'b0;
    end else begin : g_reg
      assign bus.busy[i] = out_v && (wa3_q == ADDR_W'(i));
    end
  end
endmodule
